// File: rtl/param_updown_count.sv
// Parametrised up/down/load counter with clock enable, optional saturation,
// terminal-count and wrap status. Define UDC_WRAP_CNT_EN to add an 8-bit saturating wrap counter.
module param_updown_count #(
    parameter int WIDTH    = 4,
    parameter int MOD      = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc,
    output logic             wrap,
    output logic             at_limit
`ifdef UDC_WRAP_CNT_EN
    ,
    output logic [7:0]       wrap_cnt
`endif
);

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_UP   = 2'b01;
    localparam logic [1:0] SEL_DOWN = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    // One spare bit so MOD == 2**WIDTH never relies on natural overflow.
    localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH:0] ONE  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] ZERO = '0;

    logic [WIDTH:0] count_ext;
    logic [WIDTH:0] load_ext;
    logic [WIDTH:0] next_ext;
    logic           dir_next;
    logic           wrap_next;
    logic           at_limit_next;

    assign count_ext = {1'b0, count};
    assign load_ext  = {1'b0, load_val};

    always_comb begin
        next_ext  = count_ext;
        dir_next  = dir;
        wrap_next = 1'b0;
        if (en) begin
            case (sel)
                SEL_UP: begin
                    dir_next = 1'b1;
                    if (count_ext == LAST) begin
                        if (SATURATE == 0) begin
                            next_ext  = ZERO;
                            wrap_next = 1'b1;
                        end
                    end else begin
                        next_ext = count_ext + ONE;
                    end
                end
                SEL_DOWN: begin
                    dir_next = 1'b0;
                    if (count_ext == ZERO) begin
                        if (SATURATE == 0) begin
                            next_ext  = LAST;
                            wrap_next = 1'b1;
                        end
                    end else begin
                        next_ext = count_ext - ONE;
                    end
                end
                SEL_LOAD: next_ext = (load_ext > LAST) ? LAST : load_ext;
                SEL_HOLD: next_ext = count_ext;
                default:  next_ext = count_ext;
            endcase
        end
        at_limit_next = dir_next ? (next_ext == LAST) : (next_ext == ZERO);
    end

    assign tc = en && (((sel == SEL_UP) && (count_ext == LAST)) ||
                       ((sel == SEL_DOWN) && (count_ext == ZERO)));

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            dir      <= 1'b1;
            wrap     <= 1'b0;
            at_limit <= 1'b0;
        end else begin
            wrap <= wrap_next;
            if (en) begin
                count    <= next_ext[WIDTH-1:0];
                dir      <= dir_next;
                at_limit <= at_limit_next;
            end
        end
    end

`ifdef UDC_WRAP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_cnt <= 8'd0;
        end else if (en && (sel == SEL_LOAD)) begin
            wrap_cnt <= 8'd0;
        end else if (wrap_next && (wrap_cnt != 8'hFF)) begin
            wrap_cnt <= wrap_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_param_updown_count.sv
// Bench for param_updown_count: three configurations share one stimulus stream and
// are checked against an integer reference model through an expected queue.
module tb_param_updown_count;

    localparam int N = 3;
    localparam int MODS [N] = '{10, 10, 16};
    localparam int SATS [N] = '{0, 1, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] sel = 2'b00;
    logic [3:0] load_val = 4'd0;

    logic [3:0] cnt_o  [N];
    logic       dir_o  [N];
    logic       tc_o   [N];
    logic       wrap_o [N];
    logic       atl_o  [N];
`ifdef UDC_WRAP_CNT_EN
    logic [7:0] wc_o   [N];
`endif

    param_updown_count #(.WIDTH(4), .MOD(10), .SATURATE(0)) u_wrap10 (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .load_val(load_val),
        .count(cnt_o[0]), .dir(dir_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0]), .at_limit(atl_o[0])
`ifdef UDC_WRAP_CNT_EN
        , .wrap_cnt(wc_o[0])
`endif
    );

    param_updown_count #(.WIDTH(4), .MOD(10), .SATURATE(1)) u_sat10 (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .load_val(load_val),
        .count(cnt_o[1]), .dir(dir_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1]), .at_limit(atl_o[1])
`ifdef UDC_WRAP_CNT_EN
        , .wrap_cnt(wc_o[1])
`endif
    );

    param_updown_count #(.WIDTH(4), .MOD(16), .SATURATE(0)) u_wrap16 (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .load_val(load_val),
        .count(cnt_o[2]), .dir(dir_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2]), .at_limit(atl_o[2])
`ifdef UDC_WRAP_CNT_EN
        , .wrap_cnt(wc_o[2])
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_c [N];
    int m_d [N];
    int m_w [N];
    int m_a [N];
    int m_wc [N];

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] exp_q[$];

    task automatic check(input string tag, input int idx, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s inst%0d: observed %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    // Rules applied to integers: wrap uses modulo arithmetic, saturation clamps.
    task automatic model_edge(input int i, input logic r, input logic e, input logic [1:0] s, input int lv);
        int m;
        m = MODS[i];
        if (r) begin
            m_c[i] = 0; m_d[i] = 1; m_w[i] = 0; m_a[i] = 0; m_wc[i] = 0;
            return;
        end
        m_w[i] = 0;
        if (!e) return;
        case (s)
            2'b01: begin
                m_d[i] = 1;
                if (SATS[i] == 0) begin
                    m_w[i] = (m_c[i] == m - 1) ? 1 : 0;
                    m_c[i] = (m_c[i] + 1) % m;
                end else begin
                    m_c[i] = (m_c[i] + 1 > m - 1) ? m - 1 : m_c[i] + 1;
                end
            end
            2'b10: begin
                m_d[i] = 0;
                if (SATS[i] == 0) begin
                    m_w[i] = (m_c[i] == 0) ? 1 : 0;
                    m_c[i] = (m_c[i] + m - 1) % m;
                end else begin
                    m_c[i] = (m_c[i] == 0) ? 0 : m_c[i] - 1;
                end
            end
            2'b11: begin
                m_c[i] = (lv > m - 1) ? m - 1 : lv;
                m_wc[i] = 0;
            end
            default: ;
        endcase
        if (m_w[i] == 1 && m_wc[i] < 255) m_wc[i]++;
        m_a[i] = (m_d[i] == 1) ? int'(m_c[i] == m - 1) : int'(m_c[i] == 0);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic e, input logic [1:0] s, input logic [3:0] lv);
        logic [6:0] exp;
        int exp_tc;
        @(negedge clk);
        rst = r; en = e; sel = s; load_val = lv;
        #1;
        for (int i = 0; i < N; i++) begin
            exp_tc = int'(e && ((s == 2'b01 && m_c[i] == MODS[i] - 1) || (s == 2'b10 && m_c[i] == 0)));
            check("tc", i, 16'(tc_o[i]), 16'(exp_tc));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            model_edge(i, r, e, s, int'(lv));
            exp_q.push_back({4'(m_c[i]), 1'(m_d[i]), 1'(m_w[i]), 1'(m_a[i])});
        end
        for (int i = 0; i < N; i++) begin
            exp = exp_q.pop_front();
            check("count", i, 16'(cnt_o[i]), 16'(exp[6:3]));
            check("dir", i, 16'(dir_o[i]), 16'(exp[2]));
            check("wrap", i, 16'(wrap_o[i]), 16'(exp[1]));
            check("at_limit", i, 16'(atl_o[i]), 16'(exp[0]));
`ifdef UDC_WRAP_CNT_EN
            check("wrap_cnt", i, 16'(wc_o[i]), 16'(m_wc[i]));
`endif
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        for (int i = 0; i < N; i++) begin
            m_c[i] = 0; m_d[i] = 1; m_w[i] = 0; m_a[i] = 0; m_wc[i] = 0;
        end

        step(1'b1, 1'b0, 2'b00, 4'd0);
        step(1'b1, 1'b1, 2'b01, 4'd0);
        // Reset state independent of the model.
        check("rst_count", 0, 16'(cnt_o[0]), 16'd0);
        check("rst_dir", 0, 16'(dir_o[0]), 16'd1);

        // Up 12: 0..9,0,1,2 with one wrap on MOD=10.
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 2'b01, 4'd0);
        check("up12_count", 0, 16'(cnt_o[0]), 16'd2);
        check("up12_sat", 1, 16'(cnt_o[1]), 16'd9);

        // Down 4 from 2: 1,0,9,8.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 2'b10, 4'd0);
        check("down4_count", 0, 16'(cnt_o[0]), 16'd8);

        // Saturation runs.
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 2'b01, 4'd0);
        for (int k = 0; k < 11; k++) step(1'b0, 1'b1, 2'b10, 4'd0);
        check("sat_floor", 1, 16'(cnt_o[1]), 16'd0);
        check("sat_floor_atl", 1, 16'(atl_o[1]), 16'd1);

        // Load, clipped load, then frozen by en=0.
        step(1'b0, 1'b1, 2'b11, 4'd6);
        check("load6", 0, 16'(cnt_o[0]), 16'd6);
        step(1'b0, 1'b1, 2'b11, 4'd15);
        check("load_clip", 0, 16'(cnt_o[0]), 16'd9);
        check("load_full", 2, 16'(cnt_o[2]), 16'd15);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 2'b01, 4'd0);
        check("en0_hold", 0, 16'(cnt_o[0]), 16'd9);

        // Reset on the edge that would otherwise wrap.
        step(1'b1, 1'b1, 2'b01, 4'd0);
        check("rst_mid_wrap", 0, 16'(wrap_o[0]), 16'd0);
        check("rst_mid_count", 0, 16'(cnt_o[0]), 16'd0);

        // Direction change at the lower boundary.
        step(1'b0, 1'b1, 2'b10, 4'd0);
        step(1'b0, 1'b1, 2'b01, 4'd0);

        // Random stimulus with occasional resets.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)));
        end

`ifdef UDC_WRAP_CNT_EN
        // Long up run to saturate the wrap counter, then a load clears it.
        step(1'b1, 1'b0, 2'b00, 4'd0);
        for (int k = 0; k < 3010; k++) step(1'b0, 1'b1, 2'b01, 4'd0);
        check("wrap_cnt_sat", 0, 16'(wc_o[0]), 16'd255);
        step(1'b0, 1'b1, 2'b11, 4'd3);
        check("wrap_cnt_clr", 0, 16'(wc_o[0]), 16'd0);
`endif

        if (exp_q.size() != 0) begin
            n_errors++;
            $error("FAIL exp_q_drain: observed %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
